// File: rtl/signed_frame_acc_pkg.sv
// Shared types and helpers for the signed frame accumulator.
// The SIGNED_FRAME_ACC_SATURATE_EN build option is handled in signed_add_ovf_sat.
package signed_frame_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // An add overflows when both operands share a sign and the result's sign differs from it.
  // Operands are passed zero-extended to 64 bits; width selects which bit is the sign bit.
  function automatic logic add_overflows(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [63:0] sum,
                                         input int          width);
    logic [5:0] msb;
    msb = 6'(width - 1);
    return (a[msb] == b[msb]) && (sum[msb] != a[msb]);
  endfunction

endpackage

// File: rtl/signed_add_ovf_sat.sv
// Combinational WIDTH-bit two's-complement adder with overflow detection.
// With SIGNED_FRAME_ACC_SATURATE_EN defined, overflowing results clamp to the signed range.
module signed_add_ovf_sat
  import signed_frame_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_raw;
  logic             w_ovf;

  assign w_raw = i_a + i_b;
  assign w_ovf = add_overflows(64'(i_a), 64'(i_b), 64'(w_raw), WIDTH);
  assign o_ovf = w_ovf;

`ifdef SIGNED_FRAME_ACC_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Overflow implies both operands share a sign, so i_a's sign picks the clamp direction.
  always_comb begin
    o_sum = w_raw;
    if (w_ovf) begin
      o_sum = i_a[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/signed_frame_accumulator.sv
// Accumulates signed samples into a frame sum with sticky overflow and beat count.
// Optional build macro SIGNED_FRAME_ACC_SATURATE_EN selects saturating adds instead of wrap.
module signed_frame_accumulator
  import signed_frame_acc_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int MAX_LEN = 16,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_ovf;
  logic [CNT_W-1:0] r_out_cnt;

  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_frame_end;

  signed_add_ovf_sat #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a   (r_acc),
    .i_b   (in_data),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // clear suppresses acceptance even though in_ready may read 1 in that cycle.
  assign w_accept    = in_valid && r_in_ready && (r_state == ACCUM) && !clear;
  assign w_cnt_next  = r_cnt + CNT_W'(1);
  assign w_frame_end = in_last || (w_cnt_next == CNT_W'(MAX_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_cnt   <= '0;
    end else if (clear) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          // Also raises in_ready on the first edge after reset release.
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (w_frame_end) begin
              r_out_sum   <= w_sum;
              r_out_ovf   <= r_ovf | w_add_ovf;
              r_out_cnt   <= w_cnt_next;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= HOLD;
              r_acc       <= '0;
              r_ovf       <= 1'b0;
              r_cnt       <= '0;
            end else begin
              r_acc <= w_sum;
              r_ovf <= r_ovf | w_add_ovf;
              r_cnt <= w_cnt_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ACCUM;
          end
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_overflow = r_out_ovf;
  assign out_count    = r_out_cnt;

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Directed self-checking bench for signed_frame_accumulator at WIDTH=4, MAX_LEN=4.
// Expected sums follow SIGNED_FRAME_ACC_SATURATE_EN when the bench is built with it.
module tb_signed_frame_accumulator;

  localparam int WIDTH   = 4;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_overflow;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;

`ifdef SIGNED_FRAME_ACC_SATURATE_EN
  localparam logic [3:0] EXP_7P1   = 4'd7;
  localparam logic [3:0] EXP_7P1M3 = 4'd4;
  localparam logic [3:0] EXP_M8M1  = 4'h8;
`else
  localparam logic [3:0] EXP_7P1   = 4'h8;
  localparam logic [3:0] EXP_7P1M3 = 4'd5;
  localparam logic [3:0] EXP_M8M1  = 4'd7;
`endif

  signed_frame_accumulator #(
    .WIDTH   (WIDTH),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  // Presents one beat at a negedge, waits (bounded) for in_ready, returns at the negedge after acceptance.
  task automatic send_beat(input logic [3:0] d, input logic last);
    int budget;
    budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (in_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (budget >= 20) begin
      errors++;
      $display("[TB] FAIL beat_accept_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_sum !== 4'd0 || out_overflow !== 1'b0 || out_count !== 3'd0) begin
      errors++; $display("[TB] FAIL rst_outputs: got sum=%h ovf=%b cnt=%0d want 0/0/0", out_sum, out_overflow, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rel_in_ready_pre_edge: got %b want 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_in_ready_post_edge: got %b want 1", in_ready); end
  endtask

  task automatic test_basic_frame();
    send_beat(4'd3, 1'b0);
    send_beat(4'd2, 1'b0);
    in_valid = 1'b1; in_data = 4'hF; in_last = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_early: got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== 4'd4 || out_overflow !== 1'b0 || out_count !== 3'd3) begin
      errors++; $display("[TB] FAIL basic_result: got sum=%h ovf=%b cnt=%0d want 4/0/3", out_sum, out_overflow, out_count);
    end
    take_result();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_overflow();
    send_beat(4'd7, 1'b0);
    send_beat(4'd1, 1'b1);
    checks++; if (out_sum !== EXP_7P1 || out_overflow !== 1'b1 || out_count !== 3'd2) begin
      errors++; $display("[TB] FAIL ovf_result: got sum=%h ovf=%b cnt=%0d want %h/1/2", out_sum, out_overflow, out_count, EXP_7P1);
    end
    take_result();
    send_beat(4'd7, 1'b0);
    send_beat(4'd1, 1'b0);
    send_beat(4'hD, 1'b1);
    checks++; if (out_sum !== EXP_7P1M3 || out_overflow !== 1'b1 || out_count !== 3'd3) begin
      errors++; $display("[TB] FAIL sticky_result: got sum=%h ovf=%b cnt=%0d want %h/1/3", out_sum, out_overflow, out_count, EXP_7P1M3);
    end
    take_result();
    send_beat(4'hC, 1'b0);
    send_beat(4'hC, 1'b1);
    checks++; if (out_sum !== 4'h8 || out_overflow !== 1'b0 || out_count !== 3'd2) begin
      errors++; $display("[TB] FAIL min_exact: got sum=%h ovf=%b cnt=%0d want 8/0/2", out_sum, out_overflow, out_count);
    end
    take_result();
    send_beat(4'd7, 1'b0);
    send_beat(4'h8, 1'b1);
    checks++; if (out_sum !== 4'hF || out_overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL mixed_sign: got sum=%h ovf=%b want f/0", out_sum, out_overflow);
    end
    take_result();
  endtask

  task automatic test_auto_end();
    for (int i = 0; i < 4; i++) send_beat(4'd1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_sum !== 4'd4 || out_overflow !== 1'b0 || out_count !== 3'd4) begin
      errors++; $display("[TB] FAIL auto_end: got v=%b sum=%h ovf=%b cnt=%0d want 1/4/0/4", out_valid, out_sum, out_overflow, out_count);
    end
    in_valid = 1'b1; in_data = 4'd2; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_count !== 3'd4) begin
        errors++; $display("[TB] FAIL auto_stall: got in_ready=%b v=%b cnt=%0d want 0/1/4", in_ready, out_valid, out_count);
      end
    end
    take_result();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL auto_release: got in_ready=%b v=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sum !== 4'd2 || out_overflow !== 1'b0 || out_count !== 3'd1) begin
      errors++; $display("[TB] FAIL single_beat: got v=%b sum=%h ovf=%b cnt=%0d want 1/2/0/1", out_valid, out_sum, out_overflow, out_count);
    end
    take_result();
    for (int i = 0; i < 3; i++) send_beat(4'd1, 1'b0);
    send_beat(4'd1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_count !== 3'd4 || out_sum !== 4'd4) begin
      errors++; $display("[TB] FAIL last_at_max: got v=%b cnt=%0d sum=%h want 1/4/4", out_valid, out_count, out_sum);
    end
    take_result();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL last_at_max_single: got v=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_hold_stable();
    send_beat(4'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 4'd3 || out_count !== 3'd1 || out_overflow !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_stable: got v=%b rdy=%b sum=%h cnt=%0d ovf=%b want 1/0/3/1/0", out_valid, in_ready, out_sum, out_count, out_overflow);
      end
    end
    take_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release: got in_ready=%b want 1", in_ready); end
    send_beat(4'h8, 1'b0);
    send_beat(4'hF, 1'b1);
    checks++; if (out_sum !== EXP_M8M1 || out_overflow !== 1'b1 || out_count !== 3'd2) begin
      errors++; $display("[TB] FAIL neg_ovf: got sum=%h ovf=%b cnt=%0d want %h/1/2", out_sum, out_overflow, out_count, EXP_M8M1);
    end
    take_result();
  endtask

  task automatic test_async_reset();
    send_beat(4'd5, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_sum !== 4'd0 || out_count !== 3'd0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_hold: got v=%b sum=%h cnt=%0d rdy=%b want 0/0/0/0", out_valid, out_sum, out_count, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(4'd2, 1'b0);
    send_beat(4'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid: got rdy=%b v=%b want 0/0", in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(4'd1, 1'b1);
    checks++; if (out_sum !== 4'd1 || out_count !== 3'd1 || out_overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_fresh: got sum=%h cnt=%0d ovf=%b want 1/1/0", out_sum, out_count, out_overflow);
    end
    take_result();
  endtask

  task automatic test_clear();
    send_beat(4'd6, 1'b1);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd5; in_last = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_hold: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    send_beat(4'd2, 1'b1);
    checks++; if (out_sum !== 4'd2 || out_count !== 3'd1) begin
      errors++; $display("[TB] FAIL clear_next: got sum=%h cnt=%0d want 2/1", out_sum, out_count);
    end
    take_result();
    send_beat(4'd3, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd4; in_last = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_mid_valid: got %b want 0", out_valid); end
    send_beat(4'd1, 1'b1);
    checks++; if (out_sum !== 4'd1 || out_count !== 3'd1 || out_overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_mid_next: got sum=%h cnt=%0d ovf=%b want 1/1/0", out_sum, out_count, out_overflow);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_auto_end();
    test_hold_stable();
    test_async_reset();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
